// File: rtl/fifo_rd_stream.sv
// Read-side adapter that drains a synchronous FIFO into a valid/ready stream through a 3-entry buffer.
// The optional pop counter is built only when FIFO_RD_STATS_EN is defined.
module fifo_rd_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    output logic             rd_en,
    input  logic [WIDTH-1:0] data_out,
    input  logic             read_error,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             err_sticky,
    input  logic             err_clr
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      pop_count
`endif
);

    logic [WIDTH-1:0] r_buf [3];
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic             r_errSticky;

    logic [2:0]       w_pending;
    logic             w_push;
    logic             w_pop;

    function automatic logic [1:0] nextPtr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a slot for the word already requested, so the buffer can never overflow.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight};
    assign rd_en     = !rst && !empty && (w_pending < 3'd3);

    assign w_push  = r_inflight && !read_error;
    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_buf[r_head];
    assign w_pop   = m_valid && m_ready;

    assign err_sticky = r_errSticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
            r_head      <= 2'd0;
            r_tail      <= 2'd0;
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
            r_errSticky <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf[r_tail] <= data_out;
                r_tail        <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            r_occ      <= r_occ + 2'(w_push) - 2'(w_pop);
            r_inflight <= rd_en;
            // A new error outranks a clear in the same cycle.
            if (read_error) begin
                r_errSticky <= 1'b1;
            end else if (err_clr) begin
                r_errSticky <= 1'b0;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [15:0] r_popCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_popCount <= 16'd0;
        end else if (w_pop) begin
            r_popCount <= r_popCount + 16'd1;
        end
    end

    assign pop_count = r_popCount;
`endif

endmodule
